csr_stream_fifo: RTL and testbench

// CSR-mapped bidirectional stream mailbox on the sys_clk side of the GPMC bridge. Consumes the

---
 rtl/csr_stream_fifo.sv | 127 ++++++++++++
 tb/tb_csr_stream_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_stream_fifo.sv
// CSR-mapped stream mailbox: host pushes a TX FIFO drained by a stb/ack stream and
// pops an RX FIFO filled by a stb/ack stream; status, levels and sticky errors readable.
module csr_stream_fifo #(
    parameter logic [3:0]  CSR_ID     = 4'h0,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_adr,
    input  logic        csr_we,
    input  logic [15:0] csr_dat_w,
    output logic [15:0] csr_dat_r,
    output logic        tx_stb,
    input  logic        tx_ack,
    output logic [15:0] tx_data,
    input  logic        rx_stb,
    output logic        rx_ack,
    input  logic [15:0] rx_data
);
    localparam int unsigned           DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [15:0]           tx_mem [DEPTH];
    logic [15:0]           rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [DEPTH_LOG2:0]   tx_cnt, rx_cnt;
    logic                  tx_en, tx_ovf, rx_udf;

    logic        sel, wr;
    logic [2:0]  idx;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        tx_push, tx_pop, tx_ovf_set, tx_flush;
    logic        rx_push, rx_pop, rx_udf_set, rx_flush;
    logic [15:0] rx_head, rd_mux;
    logic        unused_adr;

    assign unused_adr = ^csr_adr[9:3];

    assign sel = (csr_adr[13:10] == CSR_ID);
    assign idx = csr_adr[2:0];
    assign wr  = sel & csr_we;

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);

    assign tx_stb  = tx_en & ~tx_empty;
    assign tx_data = tx_mem[tx_rp];
    assign rx_ack  = ~rx_full;
    assign rx_head = rx_empty ? '0 : rx_mem[rx_rp];

    assign tx_pop     = tx_stb & tx_ack;
    assign tx_push    = wr && (idx == 3'd1) && !tx_full;
    assign tx_ovf_set = wr && (idx == 3'd1) && tx_full;
    assign tx_flush   = wr && (idx == 3'd5) && csr_dat_w[1];
    assign rx_push    = rx_stb & rx_ack;
    assign rx_pop     = wr && (idx == 3'd2) && !rx_empty;
    assign rx_udf_set = wr && (idx == 3'd2) && rx_empty;
    assign rx_flush   = wr && (idx == 3'd5) && csr_dat_w[2];

    always_comb begin
        rd_mux = '0;
        if (sel) begin
            case (idx)
                3'd0: rd_mux = {9'b0, rx_udf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full, tx_en};
                3'd2: rd_mux = rx_head;
                3'd3: rd_mux = 16'(tx_cnt);
                3'd4: rd_mux = 16'(rx_cnt);
                3'd5: rd_mux = {15'b0, tx_en};
                default: rd_mux = '0;
            endcase
        end
    end

    // RAM is left uninitialised; pointers and counts alone define contents.
    always_ff @(posedge sys_clk) begin
        if (tx_push) tx_mem[tx_wp] <= csr_dat_w;
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_wp     <= '0;
            tx_rp     <= '0;
            tx_cnt    <= '0;
            rx_wp     <= '0;
            rx_rp     <= '0;
            rx_cnt    <= '0;
            tx_en     <= 1'b0;
            tx_ovf    <= 1'b0;
            rx_udf    <= 1'b0;
            csr_dat_r <= '0;
        end else begin
            csr_dat_r <= rd_mux;

            if (wr && idx == 3'd5) tx_en <= csr_dat_w[0];
            // Set beats a same-cycle write-1-to-clear.
            tx_ovf <= tx_ovf_set | (tx_ovf & ~(wr && idx == 3'd0 && csr_dat_w[5]));
            rx_udf <= rx_udf_set | (rx_udf & ~(wr && idx == 3'd0 && csr_dat_w[6]));

            if (tx_flush) begin
                tx_wp  <= '0;
                tx_rp  <= '0;
                tx_cnt <= '0;
            end else begin
                if (tx_push) tx_wp <= tx_wp + PTR_ONE;
                if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
                if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CNT_ONE;
                else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CNT_ONE;
            end

            if (rx_flush) begin
                rx_wp  <= '0;
                rx_rp  <= '0;
                rx_cnt <= '0;
            end else begin
                if (rx_push) rx_wp <= rx_wp + PTR_ONE;
                if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
                if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CNT_ONE;
                else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_csr_stream_fifo.sv
// Bench for csr_stream_fifo: queue-based reference model updated per clock, with a
// negedge monitor comparing read data and stream outputs against the model.
module tb_csr_stream_fifo;
    localparam logic [3:0] ID = 4'h3;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [13:0] csr_adr;
    logic        csr_we;
    logic [15:0] csr_dat_w;
    logic [15:0] csr_dat_r;
    logic        tx_stb, tx_ack;
    logic [15:0] tx_data;
    logic        rx_stb, rx_ack;
    logic [15:0] rx_data;

    csr_stream_fifo #(.CSR_ID(ID), .DEPTH_LOG2(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .csr_adr(csr_adr), .csr_we(csr_we), .csr_dat_w(csr_dat_w), .csr_dat_r(csr_dat_r),
        .tx_stb(tx_stb), .tx_ack(tx_ack), .tx_data(tx_data),
        .rx_stb(rx_stb), .rx_ack(rx_ack), .rx_data(rx_data)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_fail = 0;
    logic mon_on = 1'b0;

    // Reference model state
    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];
    logic [15:0] exp_rd[$];
    logic        m_tx_en = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
    logic        m_sel, m_wr;
    logic [2:0]  m_idx;
    logic [15:0] rv;
    int          tx_n, rx_n;

    always @(posedge sys_clk) begin
        m_sel = (csr_adr[13:10] == ID);
        m_idx = csr_adr[2:0];
        m_wr  = m_sel && csr_we;
        rv = 16'h0;
        if (!sys_rst && m_sel) begin
            case (m_idx)
                3'd0: rv = {9'b0, m_udf, m_ovf, rx_q.size() == 0, rx_q.size() == 16,
                            tx_q.size() == 0, tx_q.size() == 16, m_tx_en};
                3'd2: rv = (rx_q.size() > 0) ? rx_q[0] : 16'h0;
                3'd3: rv = 16'(tx_q.size());
                3'd4: rv = 16'(rx_q.size());
                3'd5: rv = {15'b0, m_tx_en};
                default: rv = 16'h0;
            endcase
        end
        exp_rd.push_back(rv);
        if (sys_rst) begin
            tx_q.delete();
            rx_q.delete();
            m_tx_en = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            tx_n = tx_q.size();
            rx_n = rx_q.size();
            if (m_tx_en && tx_n > 0 && tx_ack) void'(tx_q.pop_front());
            if (m_wr && m_idx == 3'd0) begin
                if (csr_dat_w[5]) m_ovf = 1'b0;
                if (csr_dat_w[6]) m_udf = 1'b0;
            end
            if (m_wr && m_idx == 3'd1) begin
                if (tx_n == 16) m_ovf = 1'b1;
                else tx_q.push_back(csr_dat_w);
            end
            if (m_wr && m_idx == 3'd2) begin
                if (rx_n == 0) m_udf = 1'b1;
                else void'(rx_q.pop_front());
            end
            if (rx_stb && rx_n < 16) rx_q.push_back(rx_data);
            if (m_wr && m_idx == 3'd5) begin
                m_tx_en = csr_dat_w[0];
                if (csr_dat_w[1]) tx_q.delete();
                if (csr_dat_w[2]) rx_q.delete();
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: registered outputs settle after posedge; compare at negedge
    always @(negedge sys_clk) begin
        if (mon_on) begin
            if (exp_rd.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_queue: got empty expected entry at %0t", $time);
            end else begin
                chk("csr_dat_r", csr_dat_r, exp_rd.pop_front());
            end
            chk("tx_stb", 16'(tx_stb), 16'(m_tx_en && tx_q.size() > 0));
            chk("rx_ack", 16'(rx_ack), 16'(rx_q.size() < 16));
            if (tx_stb && tx_q.size() > 0) chk("tx_data", tx_data, tx_q[0]);
        end
    end

    task automatic cyc(input logic [3:0] bank, input logic [2:0] idx, input logic we,
                       input logic [15:0] d);
        @(negedge sys_clk);
        csr_adr   = {bank, 7'($urandom), idx};
        csr_we    = we;
        csr_dat_w = d;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [15:0] d);
        cyc(ID, idx, 1'b1, d);
    endtask

    task automatic rd(input logic [2:0] idx);
        cyc(ID, idx, 1'b0, 16'h0);
    endtask

    initial begin
        logic [3:0]  bank;
        logic [2:0]  idx;
        logic        we;
        logic [15:0] d;
        int          r;

        sys_rst = 1'b1;
        csr_adr = '0;
        csr_we = 1'b0;
        csr_dat_w = '0;
        tx_ack = 1'b0;
        rx_stb = 1'b0;
        rx_data = '0;
        @(posedge sys_clk);
        mon_on = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        rd(0);
        rd(0);

        // TX stream drains in order once enabled
        tx_ack = 1'b1;
        wr(1, 16'hA001);
        wr(1, 16'hA002);
        wr(1, 16'hA003);
        wr(5, 16'h0001);
        for (int i = 0; i < 5; i++) rd(3);
        rd(0);

        // Overflow with stream disabled, then clear and drain
        tx_ack = 1'b0;
        wr(5, 16'h0000);
        for (int i = 0; i < 17; i++) wr(1, 16'hB000 + 16'(i));
        rd(3);
        rd(0);
        wr(0, 16'h0020);
        rd(0);
        tx_ack = 1'b1;
        wr(5, 16'h0001);
        for (int i = 0; i < 18; i++) rd(3);
        rd(0);

        // RX fill to full with stb held, then pop past empty
        for (int i = 0; i < 20; i++) begin
            rx_stb = 1'b1;
            rx_data = 16'hC000 + 16'(i);
            rd(4);
        end
        rx_stb = 1'b0;
        rd(2);
        rd(0);
        for (int i = 0; i < 17; i++) begin
            wr(2, 16'h0);
            rd(2);
        end
        rd(0);
        wr(0, 16'h0040);
        rd(0);

        // Simultaneous RX stream push and CSR pop at level 5
        for (int i = 0; i < 5; i++) begin
            rx_stb = 1'b1;
            rx_data = 16'hD000 + 16'(i);
            rd(4);
        end
        for (int i = 0; i < 4; i++) begin
            rx_data = 16'hD100 + 16'(i);
            wr(2, 16'h0);
        end
        rx_stb = 1'b0;
        rd(4);
        for (int i = 0; i < 5; i++) begin
            rd(2);
            wr(2, 16'h0);
        end
        rd(4);

        // Other bank: reads return 0, writes ignored
        cyc(4'h2, 3'd1, 1'b1, 16'hDEAD);
        cyc(4'h2, 3'd5, 1'b1, 16'h0006);
        cyc(4'h2, 3'd2, 1'b1, 16'h0000);
        cyc(4'h2, 3'd0, 1'b0, 16'h0000);
        cyc(4'h2, 3'd5, 1'b0, 16'h0000);
        rd(0);
        rd(3);
        rd(5);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bank = ($urandom_range(0, 15) == 0) ? 4'h2 : ID;
            r = int'($urandom_range(0, 9));
            idx = (r < 3) ? 3'd1 : (r < 5) ? 3'd2 : 3'($urandom_range(0, 7));
            we = ($urandom_range(0, 2) == 0);
            d = 16'($urandom);
            if (idx == 3'd5) begin
                d[0] = ($urandom_range(0, 3) != 0);
                d[1] = ($urandom_range(0, 15) == 0);
                d[2] = ($urandom_range(0, 15) == 0);
            end
            if (((i / 500) % 2) == 0) begin
                tx_ack = ($urandom_range(0, 3) == 0);
                rx_stb = ($urandom_range(0, 3) != 0);
            end else begin
                tx_ack = ($urandom_range(0, 3) != 0);
                rx_stb = ($urandom_range(0, 3) == 0);
            end
            rx_data = 16'($urandom);
            cyc(bank, idx, we, d);
        end

        // Reset mid-transfer discards contents
        tx_ack = 1'b0;
        rx_stb = 1'b1;
        wr(1, 16'h1234);
        wr(5, 16'h0001);
        sys_rst = 1'b1;
        rd(0);
        sys_rst = 1'b0;
        rx_stb = 1'b0;
        rd(0);
        rd(3);
        rd(4);
        rd(5);
        repeat (3) @(negedge sys_clk);
        @(posedge sys_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
